// File: rtl/axi_mst_bridge_if.sv
// System-bus width package and the bundled port interface of the AXI4 master
// bridge: AXI master channels plus the initiator request/write/response ports.
package types_amba_pkg;
    localparam int CFG_SYSBUS_ADDR_BITS  = 48;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
    localparam int CFG_SYSBUS_ID_BITS    = 5;
    localparam int CFG_SYSBUS_USER_BITS  = 1;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
    } axi4_metadata_type;

    typedef struct packed {
        logic                             aw_valid;
        axi4_metadata_type                aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
        logic                             w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
        logic                             w_last;
        logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
        logic                             b_ready;
        logic                             ar_valid;
        axi4_metadata_type                ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
        logic                             r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic                             aw_ready;
        logic                             w_ready;
        logic                             b_valid;
        logic [1:0]                       b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
        logic                             ar_ready;
        logic                             r_valid;
        logic [1:0]                       r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
        logic                             r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
    } axi4_master_in_type;
endpackage

interface axi_mst_bridge_if;
    import types_amba_pkg::*;

    axi4_master_in_type                xmsti;
    axi4_master_out_type               xmsto;
    logic                              req_valid;
    logic                              req_ready;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]   req_addr;
    logic                              req_write;
    logic [2:0]                        req_size;
    logic [7:0]                        req_len;
    logic [1:0]                        req_burst;
    logic [CFG_SYSBUS_ID_BITS-1:0]     req_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]   req_user;
    logic                              wvalid;
    logic                              wready;
    logic [CFG_SYSBUS_DATA_BITS-1:0]   wdata;
    logic [CFG_SYSBUS_DATA_BYTES-1:0]  wstrb;
    logic                              resp_valid;
    logic                              resp_ready;
    logic [CFG_SYSBUS_DATA_BITS-1:0]   resp_rdata;
    logic                              resp_last;
    logic                              resp_err;

    // Bridge side: consumes requests and AXI slave channels.
    modport slave (
        input  xmsti, req_valid, req_addr, req_write, req_size, req_len,
               req_burst, req_id, req_user, wvalid, wdata, wstrb, resp_ready,
        output xmsto, req_ready, wready, resp_valid, resp_rdata, resp_last, resp_err
    );

    // Initiator plus AXI slave side.
    modport master (
        output xmsti, req_valid, req_addr, req_write, req_size, req_len,
               req_burst, req_id, req_user, wvalid, wdata, wstrb, resp_ready,
        input  xmsto, req_ready, wready, resp_valid, resp_rdata, resp_last, resp_err
    );
endinterface

// File: rtl/axi_mst_bridge.sv
// AXI4 master adapter: one outstanding request/response transaction at a time
// mapped onto AR/R or AW/W/B, with a one-entry response register.
module axi_mst_bridge
    import types_amba_pkg::*;
(
    input logic             i_clk,
    input logic             i_nrst,
    axi_mst_bridge_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B} state_e;

    state_e                            state_q;
    logic                              req_ready_q;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]   addr_q;
    logic [2:0]                        size_q;
    logic [7:0]                        len_q;
    logic [1:0]                        burst_q;
    logic [CFG_SYSBUS_ID_BITS-1:0]     id_q;
    logic [CFG_SYSBUS_USER_BITS-1:0]   user_q;
    logic [7:0]                        cnt_q;
    logic                              ar_valid_q;
    logic                              aw_valid_q;
    logic                              w_valid_q;
    logic                              w_last_q;
    logic                              w_done_q;
    logic [CFG_SYSBUS_DATA_BITS-1:0]   w_data_q;
    logic [CFG_SYSBUS_DATA_BYTES-1:0]  w_strb_q;
    logic                              resp_valid_q;
    logic [CFG_SYSBUS_DATA_BITS-1:0]   resp_rdata_q;
    logic                              resp_last_q;
    logic                              resp_err_q;

    logic resp_free;
    logic r_ready_c;
    logic b_ready_c;
    logic wready_c;
    logic req_hs;
    logic w_load;
    logic w_hs;
    logic r_hs;
    logic b_hs;
    logic unused_in;

    // Response channels may only advance when the response register can take a beat.
    assign resp_free = !resp_valid_q || bus.resp_ready;
    assign r_ready_c = (state_q == ST_R) && resp_free;
    assign b_ready_c = (state_q == ST_B) && resp_free;
    // w_done_q blocks extra initiator beats once beat len has been buffered.
    assign wready_c  = (state_q == ST_W) && !w_done_q && (!w_valid_q || bus.xmsti.w_ready);
    assign req_hs    = bus.req_valid && req_ready_q;
    assign w_load    = bus.wvalid && wready_c;
    assign w_hs      = w_valid_q && bus.xmsti.w_ready;
    assign r_hs      = bus.xmsti.r_valid && r_ready_c;
    assign b_hs      = bus.xmsti.b_valid && b_ready_c;

    assign unused_in = ^{bus.xmsti.b_id, bus.xmsti.b_user, bus.xmsti.b_resp[0],
                         bus.xmsti.r_id, bus.xmsti.r_user, bus.xmsti.r_resp[0]};

    always_comb begin
        bus.xmsto                = '0;
        bus.xmsto.ar_valid       = ar_valid_q;
        bus.xmsto.ar_bits.addr   = addr_q;
        bus.xmsto.ar_bits.len    = len_q;
        bus.xmsto.ar_bits.size   = size_q;
        bus.xmsto.ar_bits.burst  = burst_q;
        bus.xmsto.ar_bits.cache  = 4'b0011;
        bus.xmsto.ar_id          = id_q;
        bus.xmsto.ar_user        = user_q;
        bus.xmsto.aw_valid       = aw_valid_q;
        bus.xmsto.aw_bits.addr   = addr_q;
        bus.xmsto.aw_bits.len    = len_q;
        bus.xmsto.aw_bits.size   = size_q;
        bus.xmsto.aw_bits.burst  = burst_q;
        bus.xmsto.aw_bits.cache  = 4'b0011;
        bus.xmsto.aw_id          = id_q;
        bus.xmsto.aw_user        = user_q;
        bus.xmsto.w_valid        = w_valid_q;
        bus.xmsto.w_data         = w_data_q;
        bus.xmsto.w_strb         = w_strb_q;
        bus.xmsto.w_last         = w_last_q;
        bus.xmsto.w_user         = user_q;
        bus.xmsto.r_ready        = r_ready_c;
        bus.xmsto.b_ready        = b_ready_c;
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.wready     = wready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_last  = resp_last_q;
    assign bus.resp_err   = resp_err_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            addr_q       <= '0;
            size_q       <= '0;
            len_q        <= '0;
            burst_q      <= '0;
            id_q         <= '0;
            user_q       <= '0;
            cnt_q        <= '0;
            ar_valid_q   <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            w_last_q     <= 1'b0;
            w_done_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            // A new beat loading the response register wins over a drain.
            if (r_hs) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= bus.xmsti.r_data;
                resp_last_q  <= bus.xmsti.r_last;
                resp_err_q   <= bus.xmsti.r_resp[1];
            end else if (b_hs) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= '0;
                resp_last_q  <= 1'b1;
                resp_err_q   <= bus.xmsti.b_resp[1];
            end else if (bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (req_hs) begin
                        addr_q      <= bus.req_addr;
                        size_q      <= bus.req_size;
                        len_q       <= bus.req_len;
                        burst_q     <= bus.req_burst;
                        id_q        <= bus.req_id;
                        user_q      <= bus.req_user;
                        cnt_q       <= '0;
                        w_done_q    <= 1'b0;
                        req_ready_q <= 1'b0;
                        if (bus.req_write) begin
                            aw_valid_q <= 1'b1;
                            state_q    <= ST_AW;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (bus.xmsti.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs && bus.xmsti.r_last) begin
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (bus.xmsti.aw_ready) begin
                        aw_valid_q <= 1'b0;
                        state_q    <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                    end
                    if (w_load) begin
                        w_valid_q <= 1'b1;
                        w_data_q  <= bus.wdata;
                        w_strb_q  <= bus.wstrb;
                        w_last_q  <= (cnt_q == len_q);
                        cnt_q     <= cnt_q + 8'd1;
                        if (cnt_q == len_q) begin
                            w_done_q <= 1'b1;
                        end
                    end
                    if (w_hs && w_last_q) begin
                        state_q <= ST_B;
                    end
                end
                ST_B: begin
                    if (b_hs) begin
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mst_bridge.sv
// Scoreboard bench for axi_mst_bridge: directed requests with a reactive AXI
// slave model; monitors compare AXI beats and responses against queued values.
module tb_axi_mst_bridge;
    import types_amba_pkg::*;

    logic clk;
    logic nrst;

    axi_mst_bridge_if bus();

    axi_mst_bridge dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {logic [63:0] data; logic last; logic err;} resp_t;
    typedef struct {logic wr; logic [63:0] addr; logic [7:0] len;} addr_t;
    typedef struct {logic [63:0] data; logic [7:0] strb; logic last;} wbeat_t;
    typedef struct {logic [63:0] data; logic [1:0] resp;} rbeat_t;

    resp_t  exp_resp[$];
    addr_t  exp_addr[$];
    wbeat_t exp_w[$];
    rbeat_t slv_r[$];
    logic [1:0] slv_b[$];

    int n_chk  = 0;
    int n_fail = 0;
    int r_hs_cnt = 0;
    int w_hs_cnt = 0;
    logic resp_toggle   = 1'b0;
    logic wready_toggle = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: beat seen with no expected entry at %0t", nm, $time);
    endtask

    // Monitor: all handshakes are sampled half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.xmsto.ar_valid && bus.xmsti.ar_ready) begin
                if (exp_addr.size() == 0) unexpected("ar_hs");
                else begin
                    addr_t e;
                    e = exp_addr.pop_front();
                    chk("ar_dir",   64'(e.wr), 64'd0);
                    chk("ar_addr",  64'(bus.xmsto.ar_bits.addr), e.addr);
                    chk("ar_len",   64'(bus.xmsto.ar_bits.len), 64'(e.len));
                    chk("ar_cache", 64'(bus.xmsto.ar_bits.cache), 64'h3);
                    $display("AR addr=0x%0h len=%0d", bus.xmsto.ar_bits.addr, bus.xmsto.ar_bits.len);
                end
            end
            if (bus.xmsto.aw_valid && bus.xmsti.aw_ready) begin
                if (exp_addr.size() == 0) unexpected("aw_hs");
                else begin
                    addr_t e;
                    e = exp_addr.pop_front();
                    chk("aw_dir",  64'(e.wr), 64'd1);
                    chk("aw_addr", 64'(bus.xmsto.aw_bits.addr), e.addr);
                    chk("aw_len",  64'(bus.xmsto.aw_bits.len), 64'(e.len));
                    $display("AW addr=0x%0h len=%0d", bus.xmsto.aw_bits.addr, bus.xmsto.aw_bits.len);
                end
            end
            if (bus.xmsto.w_valid && bus.xmsti.w_ready) begin
                w_hs_cnt++;
                if (exp_w.size() == 0) unexpected("w_hs");
                else begin
                    wbeat_t e;
                    e = exp_w.pop_front();
                    chk("w_data", bus.xmsto.w_data, e.data);
                    chk("w_strb", 64'(bus.xmsto.w_strb), 64'(e.strb));
                    chk("w_last", 64'(bus.xmsto.w_last), 64'(e.last));
                    $display("W  data=0x%0h strb=0x%0h last=%0b", bus.xmsto.w_data, bus.xmsto.w_strb, bus.xmsto.w_last);
                end
            end
            if (bus.xmsti.r_valid && bus.xmsto.r_ready) r_hs_cnt++;
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_resp.size() == 0) unexpected("resp_hs");
                else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.data);
                    chk("resp_last",  64'(bus.resp_last), 64'(e.last));
                    chk("resp_err",   64'(bus.resp_err), 64'(e.err));
                    $display("RSP data=0x%0h last=%0b err=%0b", bus.resp_rdata, bus.resp_last, bus.resp_err);
                end
            end
            if (bus.resp_valid && !bus.resp_ready) begin
                chk("r_ready_stall", 64'(bus.xmsto.r_ready), 64'd0);
                chk("b_ready_stall", 64'(bus.xmsto.b_ready), 64'd0);
            end
        end
    end

    // AXI slave model: zero-wait address channels, R beats from slv_r, B codes from slv_b.
    initial begin : slave
        logic ar_hs, r_hs, wl_hs, b_hs;
        logic [7:0] ar_len;
        int r_left;
        rbeat_t rb;
        r_left = 0;
        bus.xmsti = '0;
        forever begin
            @(negedge clk);
            ar_hs  = bus.xmsto.ar_valid && bus.xmsti.ar_ready;
            ar_len = bus.xmsto.ar_bits.len;
            r_hs   = bus.xmsti.r_valid && bus.xmsto.r_ready;
            wl_hs  = bus.xmsto.w_valid && bus.xmsti.w_ready && bus.xmsto.w_last;
            b_hs   = bus.xmsti.b_valid && bus.xmsto.b_ready;
            @(posedge clk);
            #1;
            if (!nrst) begin
                bus.xmsti = '0;
                r_left = 0;
            end else begin
                bus.xmsti.ar_ready = 1'b1;
                bus.xmsti.aw_ready = 1'b1;
                bus.xmsti.w_ready  = wready_toggle ? ~bus.xmsti.w_ready : 1'b1;
                if (r_hs) r_left--;
                if (ar_hs) r_left = int'(ar_len) + 1;
                if (bus.xmsti.r_valid && !r_hs) begin
                    bus.xmsti.r_valid = 1'b1;
                end else if (r_left > 0) begin
                    rb = (slv_r.size() != 0) ? slv_r.pop_front() : '{data: 64'd0, resp: 2'b00};
                    bus.xmsti.r_valid = 1'b1;
                    bus.xmsti.r_data  = rb.data;
                    bus.xmsti.r_resp  = rb.resp;
                    bus.xmsti.r_last  = (r_left == 1);
                end else begin
                    bus.xmsti.r_valid = 1'b0;
                    bus.xmsti.r_last  = 1'b0;
                end
                if (b_hs) bus.xmsti.b_valid = 1'b0;
                if (wl_hs) begin
                    bus.xmsti.b_valid = 1'b1;
                    bus.xmsti.b_resp  = (slv_b.size() != 0) ? slv_b.pop_front() : 2'b00;
                end
            end
        end
    end

    initial begin : resp_drv
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.resp_ready = resp_toggle ? ~bus.resp_ready : 1'b1;
        end
    end

    task automatic send_req(input logic wr, input logic [CFG_SYSBUS_ADDR_BITS-1:0] a,
                            input logic [2:0] sz, input logic [7:0] ln, input logic [1:0] bu);
        logic hs;
        int n;
        exp_addr.push_back('{wr: wr, addr: 64'(a), len: ln});
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_size  = sz;
        bus.req_len   = ln;
        bus.req_burst = bu;
        n = 0;
        hs = 1'b0;
        do begin
            @(negedge clk);
            hs = bus.req_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!hs && n < 100);
        if (!hs) unexpected("req_timeout");
        bus.req_valid = 1'b0;
    endtask

    task automatic send_wbeat(input logic [63:0] d, input logic [7:0] s, input logic lst, input bit gap);
        logic hs;
        int n;
        exp_w.push_back('{data: d, strb: s, last: lst});
        bus.wvalid = 1'b1;
        bus.wdata  = d;
        bus.wstrb  = s;
        n = 0;
        hs = 1'b0;
        do begin
            @(negedge clk);
            hs = bus.wready;
            n++;
            @(posedge clk);
            #1;
        end while (!hs && n < 100);
        if (!hs) unexpected("wbeat_timeout");
        bus.wvalid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_resp.size() != 0 || exp_w.size() != 0 || exp_addr.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) unexpected("done_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int k;
        int base;
        bit got;
        nrst          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_len   = '0;
        bus.req_burst = '0;
        bus.req_id    = 5'd3;
        bus.req_user  = 1'b0;
        bus.wvalid    = 1'b0;
        bus.wdata     = '0;
        bus.wstrb     = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready",  64'(bus.req_ready), 64'd1);
        chk("rst_wready",     64'(bus.wready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_resp_last",  64'(bus.resp_last), 64'd0);
        chk("rst_ar_valid",   64'(bus.xmsto.ar_valid), 64'd0);
        chk("rst_aw_valid",   64'(bus.xmsto.aw_valid), 64'd0);
        chk("rst_w_valid",    64'(bus.xmsto.w_valid), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single read, zero-wait slave, latency to o_resp_valid.
        slv_r.push_back('{data: 64'hDEADBEEF_CAFEF00D, resp: 2'b00});
        exp_resp.push_back('{data: 64'hDEADBEEF_CAFEF00D, last: 1'b1, err: 1'b0});
        send_req(1'b0, 48'h1000, 3'd3, 8'd0, 2'b01);
        k = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.resp_valid) got = 1'b1;
        end
        chk("read_latency", 64'(k), 64'd3);
        wait_done();

        // Burst read with toggling response back-pressure.
        resp_toggle = 1'b1;
        slv_r.push_back('{data: 64'h1111_0000_0000_0001, resp: 2'b00});
        slv_r.push_back('{data: 64'h2222_0000_0000_0002, resp: 2'b00});
        slv_r.push_back('{data: 64'h3333_0000_0000_0003, resp: 2'b00});
        slv_r.push_back('{data: 64'h4444_0000_0000_0004, resp: 2'b00});
        exp_resp.push_back('{data: 64'h1111_0000_0000_0001, last: 1'b0, err: 1'b0});
        exp_resp.push_back('{data: 64'h2222_0000_0000_0002, last: 1'b0, err: 1'b0});
        exp_resp.push_back('{data: 64'h3333_0000_0000_0003, last: 1'b0, err: 1'b0});
        exp_resp.push_back('{data: 64'h4444_0000_0000_0004, last: 1'b1, err: 1'b0});
        send_req(1'b0, 48'h3000, 3'd3, 8'd3, 2'b01);
        wait_done();
        resp_toggle = 1'b0;

        // Single write.
        slv_b.push_back(2'b00);
        exp_resp.push_back('{data: 64'd0, last: 1'b1, err: 1'b0});
        send_req(1'b1, 48'h2008, 3'd3, 8'd0, 2'b01);
        send_wbeat(64'h55, 8'h01, 1'b1, 1'b0);
        wait_done();

        // Burst write, initiator gaps and a toggling slave w_ready.
        wready_toggle = 1'b1;
        base = w_hs_cnt;
        slv_b.push_back(2'b00);
        exp_resp.push_back('{data: 64'd0, last: 1'b1, err: 1'b0});
        send_req(1'b1, 48'h4000, 3'd3, 8'd7, 2'b01);
        for (int i = 0; i < 8; i++) begin
            send_wbeat(64'h0101_0101_0101_0101 * 64'(i + 1), 8'hFF, (i == 7), 1'b1);
        end
        wait_done();
        chk("w_beat_count", 64'(w_hs_cnt - base), 64'd8);
        wready_toggle = 1'b0;

        // Read error on the second beat only, then a DECERR write.
        slv_r.push_back('{data: 64'hA5A5_A5A5_0000_0000, resp: 2'b00});
        slv_r.push_back('{data: 64'h5A5A_5A5A_FFFF_FFFF, resp: 2'b10});
        exp_resp.push_back('{data: 64'hA5A5_A5A5_0000_0000, last: 1'b0, err: 1'b0});
        exp_resp.push_back('{data: 64'h5A5A_5A5A_FFFF_FFFF, last: 1'b1, err: 1'b1});
        send_req(1'b0, 48'h7000, 3'd3, 8'd1, 2'b01);
        wait_done();
        slv_b.push_back(2'b11);
        exp_resp.push_back('{data: 64'd0, last: 1'b1, err: 1'b1});
        send_req(1'b1, 48'h7100, 3'd3, 8'd0, 2'b01);
        send_wbeat(64'hCC, 8'h0F, 1'b1, 1'b0);
        wait_done();

        // Reset in the middle of a 4-beat read, then a clean single read.
        base = r_hs_cnt;
        for (int i = 0; i < 4; i++) begin
            slv_r.push_back('{data: 64'hBEEF_0000 + 64'(i), resp: 2'b00});
            exp_resp.push_back('{data: 64'hBEEF_0000 + 64'(i), last: (i == 3), err: 1'b0});
        end
        send_req(1'b0, 48'h5000, 3'd3, 8'd3, 2'b01);
        k = 0;
        while (r_hs_cnt - base < 2 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (k >= 100) unexpected("mid_burst_timeout");
        #2;
        nrst = 1'b0;
        #1;
        chk("mid_rst_req_ready",  64'(bus.req_ready), 64'd1);
        chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("mid_rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("mid_rst_r_ready",    64'(bus.xmsto.r_ready), 64'd0);
        chk("mid_rst_ar_addr",    64'(bus.xmsto.ar_bits.addr), 64'd0);
        chk("mid_rst_wready",     64'(bus.wready), 64'd0);
        exp_resp.delete();
        exp_addr.delete();
        exp_w.delete();
        slv_r.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        slv_r.push_back('{data: 64'h0123_4567_89AB_CDEF, resp: 2'b00});
        exp_resp.push_back('{data: 64'h0123_4567_89AB_CDEF, last: 1'b1, err: 1'b0});
        send_req(1'b0, 48'h6000, 3'd3, 8'd0, 2'b01);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
